// File: rtl/reg_arb_pkg.sv
// Shared widths, defaults and the write-request record for the register-file
// write arbiter.
package reg_arb_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int REG_DATA_W        = 32;
  localparam int DEFAULT_PROT_BASE = 24;

  // One register write as seen by reg_file: target address plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready request handshake and the
// one-cycle completion response. master = requesters, slave = arbiter.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_err;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rsp_valid, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr (wrapping)
// wins. The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  int   idx;
  logic found;

  // Scan NUM_REQ slots starting at ptr; only the first valid one is granted.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the reg_file write port among NUM_REQ requesters (round-robin),
// registers the selected write one cycle after accept, and enforces a sticky
// lock over the upper address window [PROT_BASE, 2**ADDR_W-1].
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int PROT_BASE = DEFAULT_PROT_BASE,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                resetn,
  reg_write_arbiter_if.slave  bus,
  input  logic                lock_set,
  output logic                lock_status,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [CNT_W-1:0]    blocked_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  // One extra bit so a base of exactly 2**ADDR_W (nothing protected) still fits.
  localparam logic [ADDR_W:0]   PROT_LIM = (ADDR_W+1)'(PROT_BASE);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_err_q;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic               fire;
  logic               prot;
  logic               blk;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (grant)
  );

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

  // Encode the one-hot grant and pick the winner's address/data and flags.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gidx = PTR_W'(i);
    fire     = |grant;
    acc_addr = bus.req_addr[gidx];
    acc_data = bus.req_data[gidx];
    prot     = ({1'b0, acc_addr} >= PROT_LIM);
    // A lock_set arriving in the accept cycle already blocks that write.
    blk      = fire & prot & (lock_status | lock_set);
    ptr_nxt  = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
  end

  // Issue stage: registered write, response pulse, pointer, lock, counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      lock_status <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      blocked_cnt <= '0;
    end else begin
      if (fire) ptr <= ptr_nxt;
      lock_status <= lock_status | lock_set;
      // x0 is hardwired in reg_file, so an address-0 write completes silently.
      wr_en       <= fire & ~blk & (acc_addr != '0);
      wr_addr     <= fire ? acc_addr : '0;
      wr_data     <= fire ? acc_data : '0;
      rsp_valid_q <= grant;
      rsp_err_q   <= blk ? grant : '0;
      if (blk && (blocked_cnt != CNT_MAX))
        blocked_cnt <= blocked_cnt + CNT_W'(1);
    end
  end

endmodule
